// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: drives a req/ack data-memory handshake,
// stalls upstream while an access is outstanding, and latches write-back fields.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic [15:0] in_XOut,
  input  logic [15:0] in_wdata,
  input  logic        in_link,
  input  logic [15:0] in_PC_plus_two,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic [2:0]  in_WriteReg,
  input  logic        in_halt,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        out_valid,
  output logic        out_link,
  output logic        out_MemtoReg,
  output logic        out_RegWrite,
  output logic        out_halt,
  output logic [15:0] out_PC_plus_two,
  output logic [15:0] out_MemOut,
  output logic [15:0] out_XOut,
  output logic [2:0]  out_WriteReg,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StAccess, StHalted, StError} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic        link_q, link_d;
  logic        memtoreg_q, memtoreg_d;
  logic        regwrite_q, regwrite_d;
  logic        halt_q, halt_d;
  logic [15:0] pc2_q, pc2_d;
  logic [15:0] memout_q, memout_d;
  logic [15:0] xout_q, xout_d;
  logic [2:0]  wreg_q, wreg_d;

  logic memop, badop, req_c, stall_c, capture;

  assign memop = in_valid & (in_MemRead | in_MemWrite);
  assign badop = in_valid & in_MemRead & in_MemWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_c = memop & ~badop;
        if (badop || (req_c && mem_err)) begin
          stall_c = 1'b1;
          state_d = StError;
        end else if (req_c && !mem_ack) begin
          stall_c = 1'b1;
          state_d = StAccess;
          cnt_d   = '0;
        end else begin
          capture = 1'b1;
        end
      end
      StAccess: begin
        req_c = 1'b1;
        // A fault wins over an acknowledge arriving in the same cycle.
        if (mem_err) begin
          stall_c = 1'b1;
          state_d = StError;
          cnt_d   = '0;
        end else if (!mem_ack) begin
          stall_c = 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StError;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          capture = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StHalted: ;
      StError:  stall_c = 1'b1;
      default:  state_d = StError;
    endcase
    if (capture && in_valid && in_halt) state_d = StHalted;
  end

  // Non-capture cycles send a bubble to write-back; payload fields hold.
  always_comb begin
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    halt_d     = 1'b0;
    link_d     = link_q;
    memtoreg_d = memtoreg_q;
    pc2_d      = pc2_q;
    memout_d   = memout_q;
    xout_d     = xout_q;
    wreg_d     = wreg_q;
    if (capture) begin
      valid_d    = in_valid;
      regwrite_d = in_valid & in_RegWrite;
      halt_d     = in_valid & in_halt;
      link_d     = in_link;
      memtoreg_d = in_MemtoReg;
      pc2_d      = in_PC_plus_two;
      memout_d   = (in_valid && in_MemRead) ? mem_rdata : 16'h0000;
      xout_d     = in_XOut;
      wreg_d     = in_WriteReg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      link_q     <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
      pc2_q      <= '0;
      memout_q   <= '0;
      xout_q     <= '0;
      wreg_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      link_q     <= link_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      halt_q     <= halt_d;
      pc2_q      <= pc2_d;
      memout_q   <= memout_d;
      xout_q     <= xout_d;
      wreg_q     <= wreg_d;
    end
  end

  // Gating with rst_n drops the handshake immediately, even mid-access.
  assign mem_req   = req_c & rst_n;
  assign stall     = stall_c & rst_n;
  assign mem_wr    = mem_req & in_MemWrite;
  assign mem_addr  = in_XOut;
  assign mem_wdata = in_wdata;
  assign err       = (state_q == StError);

  assign out_valid       = valid_q;
  assign out_link        = link_q;
  assign out_MemtoReg    = memtoreg_q;
  assign out_RegWrite    = regwrite_q;
  assign out_halt        = halt_q;
  assign out_PC_plus_two = pc2_q;
  assign out_MemOut      = memout_q;
  assign out_XOut        = xout_q;
  assign out_WriteReg    = wreg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_wb_stage;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 0, in_MemRead = 0, in_MemWrite = 0, in_link = 0;
  logic        in_MemtoReg = 0, in_RegWrite = 0, in_halt = 0;
  logic [15:0] in_XOut = 0, in_wdata = 0, in_PC_plus_two = 0, mem_rdata = 0;
  logic [2:0]  in_WriteReg = 0;
  logic        mem_ack = 0, mem_err = 0;
  logic        stall, mem_req, mem_wr, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        out_valid, out_link, out_MemtoReg, out_RegWrite, out_halt;
  logic [15:0] out_PC_plus_two, out_MemOut, out_XOut;
  logic [2:0]  out_WriteReg;

  int n_checks = 0;
  int n_err = 0;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_XOut(in_XOut), .in_wdata(in_wdata), .in_link(in_link),
    .in_PC_plus_two(in_PC_plus_two), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
    .in_WriteReg(in_WriteReg), .in_halt(in_halt), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .out_valid(out_valid), .out_link(out_link),
    .out_MemtoReg(out_MemtoReg), .out_RegWrite(out_RegWrite), .out_halt(out_halt),
    .out_PC_plus_two(out_PC_plus_two), .out_MemOut(out_MemOut), .out_XOut(out_XOut),
    .out_WriteReg(out_WriteReg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a stage that is either faulted, halted, waiting on memory, or free.
  logic        m_err = 0, m_halt = 0, m_busy = 0;
  int          m_wait = 0;
  logic        e_valid = 0, e_link = 0, e_m2r = 0, e_rw = 0, e_halt = 0;
  logic [15:0] e_pc = 0, e_mo = 0, e_x = 0;
  logic [2:0]  e_wreg = 0;
  logic        t_memop, t_badop, t_req;

  assign t_memop = in_valid & (in_MemRead | in_MemWrite);
  assign t_badop = in_valid & in_MemRead & in_MemWrite;
  assign t_req   = t_memop & ~t_badop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err <= 0; m_halt <= 0; m_busy <= 0; m_wait <= 0;
      e_valid <= 0; e_link <= 0; e_m2r <= 0; e_rw <= 0; e_halt <= 0;
      e_pc <= 0; e_mo <= 0; e_x <= 0; e_wreg <= 0;
    end else if (!m_err && !m_halt && !(t_badop || (t_req && mem_err)) && !(t_req && !mem_ack))
    begin
      m_busy  <= 0;
      e_valid <= in_valid;
      e_rw    <= in_valid & in_RegWrite;
      e_halt  <= in_valid & in_halt;
      e_link  <= in_link;
      e_m2r   <= in_MemtoReg;
      e_pc    <= in_PC_plus_two;
      e_mo    <= (in_valid && in_MemRead) ? mem_rdata : 16'h0000;
      e_x     <= in_XOut;
      e_wreg  <= in_WriteReg;
      if (in_valid && in_halt) m_halt <= 1;
    end else begin
      e_valid <= 0; e_rw <= 0; e_halt <= 0;
      if (!m_err && !m_halt) begin
        if (t_badop || (t_req && mem_err)) begin
          m_err <= 1; m_busy <= 0;
        end else if (!m_busy) begin
          m_busy <= 1; m_wait <= 0;
        end else if (m_wait == TO - 1) begin
          m_err <= 1; m_busy <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic x_req, x_stall;
    x_req   = rst_n & ~m_err & ~m_halt & t_req;
    x_stall = rst_n & (m_err | (~m_halt & (t_badop | (t_req & (~mem_ack | mem_err)))));
    chk("mem_req", 16'(mem_req), 16'(x_req));
    chk("stall", 16'(stall), 16'(x_stall));
    if (x_req) chk("mem_wr", 16'(mem_wr), 16'(in_MemWrite));
    chk("mem_addr", mem_addr, in_XOut);
    chk("mem_wdata", mem_wdata, in_wdata);
    chk("err", 16'(err), 16'(m_err));
    chk("out_valid", 16'(out_valid), 16'(e_valid));
    chk("out_RegWrite", 16'(out_RegWrite), 16'(e_rw));
    chk("out_halt", 16'(out_halt), 16'(e_halt));
    chk("out_link", 16'(out_link), 16'(e_link));
    chk("out_MemtoReg", 16'(out_MemtoReg), 16'(e_m2r));
    chk("out_PC_plus_two", out_PC_plus_two, e_pc);
    chk("out_MemOut", out_MemOut, e_mo);
    chk("out_XOut", out_XOut, e_x);
    chk("out_WriteReg", 16'(out_WriteReg), 16'(e_wreg));
  end

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [15:0] x,
                        input logic [15:0] wd, input logic m2r, input logic rw,
                        input logic [2:0] wreg, input logic h);
    in_valid = v; in_MemRead = rd; in_MemWrite = wr; in_XOut = x; in_wdata = wd;
    in_MemtoReg = m2r; in_RegWrite = rw; in_WriteReg = wreg; in_halt = h;
    in_link = x[0]; in_PC_plus_two = x + 16'd2;
  endtask

  task automatic idle();
    set_op(0, 0, 0, 16'h0, 16'h0, 0, 0, 3'd0, 0);
    mem_ack = 0; mem_err = 0; mem_rdata = 16'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 0;
    idle();
    @(posedge clk); #3 rst_n = 1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step();
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset err", 16'(err), 16'h0);

    // ALU op
    set_op(1, 0, 0, 16'h1234, 16'h0, 0, 1, 3'd3, 0);
    mid(); chk("alu stall", 16'(stall), 16'h0);
    step();
    chk("alu out_valid", 16'(out_valid), 16'h1);
    chk("alu out_XOut", out_XOut, 16'h1234);
    chk("alu out_WriteReg", 16'(out_WriteReg), 16'h3);
    chk("alu out_RegWrite", 16'(out_RegWrite), 16'h1);

    // Load acknowledged on the fourth cycle
    set_op(1, 1, 0, 16'h0040, 16'h0, 1, 1, 3'd5, 0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      mem_rdata = (i == 3) ? 16'hBEEF : 16'h0;
      mid();
      if (stall) stalls++;
      if (i > 0) chk("load bubble", 16'(out_valid), 16'h0);
      step();
    end
    idle();
    chk("load stall cycles", 16'(stalls), 16'd3);
    chk("load out_MemOut", out_MemOut, 16'hBEEF);
    chk("load out_MemtoReg", 16'(out_MemtoReg), 16'h1);
    chk("load out_valid", 16'(out_valid), 16'h1);

    // Store with same-cycle ack
    set_op(1, 0, 1, 16'h0010, 16'h00FF, 0, 0, 3'd1, 0);
    mem_ack = 1;
    mid();
    chk("store mem_wr", 16'(mem_wr), 16'h1);
    chk("store mem_addr", mem_addr, 16'h0010);
    chk("store mem_wdata", mem_wdata, 16'h00FF);
    chk("store stall", 16'(stall), 16'h0);
    step();
    idle();
    chk("store out_MemOut", out_MemOut, 16'h0000);
    chk("store out_valid", 16'(out_valid), 16'h1);

    // Load never acknowledged: one IDLE cycle plus TO ACCESS cycles
    set_op(1, 1, 0, 16'h0080, 16'h0, 1, 1, 3'd2, 0);
    repeat (TO) step();
    chk("timeout err early", 16'(err), 16'h0);
    step();
    chk("timeout err", 16'(err), 16'h1);
    mid();
    chk("timeout mem_req", 16'(mem_req), 16'h0);
    chk("timeout stall", 16'(stall), 16'h1);
    do_reset();
    chk("reset clears err", 16'(err), 16'h0);

    // Read and write together
    set_op(1, 1, 1, 16'h0020, 16'h0, 0, 1, 3'd4, 0);
    mid(); chk("badop mem_req", 16'(mem_req), 16'h0);
    step(); chk("badop err", 16'(err), 16'h1);
    do_reset();

    // Memory fault during ACCESS
    set_op(1, 1, 0, 16'h0030, 16'h0, 1, 1, 3'd6, 0);
    step();
    mem_err = 1;
    mid(); chk("fault mem_req", 16'(mem_req), 16'h1);
    step(); chk("fault err", 16'(err), 16'h1);
    do_reset();

    // HALT then ALU ops
    set_op(1, 0, 0, 16'h0002, 16'h0, 0, 0, 3'd0, 1);
    step();
    chk("halt out_halt", 16'(out_halt), 16'h1);
    chk("halt out_valid", 16'(out_valid), 16'h1);
    set_op(1, 0, 0, 16'h5555, 16'h0, 0, 1, 3'd7, 0);
    step();
    chk("halted out_valid", 16'(out_valid), 16'h0);
    chk("halted out_halt", 16'(out_halt), 16'h0);
    step();
    chk("halted out_valid 2", 16'(out_valid), 16'h0);
    do_reset();

    // Reset asserted mid-ACCESS
    set_op(1, 1, 0, 16'h0044, 16'h0, 1, 1, 3'd1, 0);
    step();
    mid(); chk("access stall", 16'(stall), 16'h1);
    #1 rst_n = 0;
    #1 chk("reset mem_req", 16'(mem_req), 16'h0);
    chk("reset stall", 16'(stall), 16'h0);
    idle();
    @(posedge clk); #3 rst_n = 1;
    step();

    // Mixed ALU traffic, including empty slots
    for (int i = 0; i < 8; i++) begin
      set_op(1'($urandom_range(0, 1)), 0, 0, 16'($urandom), 16'h0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
